mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage pipeline.
- Consumes the rs/rt operands after the E-stage forwarding muxes have selected them, and holds the architectural HI/LO registers.
- Models multi-cycle latency with a busy counter. The stall unit uses start|busy to hold mult/div/mfhi/mflo instructions in D.
- HI/LO feed the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request from the E-stage decoder; qualifies md_op.
- md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op.
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- rt_val  input  32  forwarded rt operand (divisor / multiplier).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse in the cycle HI/LO first show a new mult/div result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - On a reset edge: busy=0, done=0, hi=0, lo=0, counter=0, pending result cleared.
  - Reset wins over start in the same cycle.
  - Reset mid-operation aborts the operation; no HI/LO write occurs.
- State machine: IDLE, RUN.
- IDLE with start=1 and md_op in 0..3 (edge T):
  - Latch the 64-bit result into an internal pending register, computed from rs_val/rt_val at that edge.
  - Load counter with MULT_CYCLES (ops 0, 1) or DIV_CYCLES (ops 2, 3); busy<=1; go to RUN.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter==1: hi/lo<=pending, busy<=0, done<=1 for the next cycle, return to IDLE.
  - busy is high for exactly N cycles (cycles T+1..T+N); new HI/LO are visible from cycle T+N+1.
  - hi/lo hold their old values throughout RUN.
- Ops 4/5 (mthi/mtlo) in IDLE: write hi (or lo) with rs_val at the next edge. Busy stays 0; the other register is unchanged; no done pulse.
- Ops 6/7, or start=0: no effect.
- start while busy=1: ignored entirely, for all ops including 4/5. The stall unit guarantees this does not occur; the RTL must still ignore it.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 -> 64.
  - div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - div boundary: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (div or divu): full busy duration still runs, but hi/lo keep their previous values; done still pulses.
- done is registered, so it is 0 in every cycle except the single post-completion cycle.

Test Plan:
1. reset, then start mult rs=0xFFFFFFFE (-2), rt=3:
   - busy high cycles 1..5.
   - hi=0xFFFFFFFF, lo=0xFFFFFFFA in cycle 6, with done=1 in cycle 6 only.
2. start multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
3. start div rs=0xFFFFFFF9 (-7), rt=2:
   - busy cycles 1..10.
   - then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
   - also check div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. With hi=0x11, lo=0x22 loaded via mthi/mtlo (busy never asserts, each write visible next cycle, other register untouched):
   - divu rs=5, rt=0 -> 10 busy cycles, done pulses, hi=0x11, lo=0x22 unchanged.
5. start mult; in busy cycle 2 drive start with divu and with mthi:
   - both ignored.
   - busy ends on schedule and result matches the original mult.
6. start div; assert reset in busy cycle 4:
   - next cycle busy=0, hi=lo=0, done never pulses.
   - reset and start together -> reset wins, busy stays 0.

Source files
------------

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Result is computed at issue and parked in r_pend until the busy countdown expires.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_pend;
  logic          r_wr;
  logic [63:0]   w_ms, w_mu, w_res;
  logic [31:0]   w_div, w_a, w_b, w_q, w_r, w_uq, w_ur;
  logic          w_dz;
  // Signed divide runs on magnitudes so INT_MIN / -1 wraps instead of trapping.
  always_comb begin
    w_ms  = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    w_mu  = {32'd0, rs_val} * {32'd0, rt_val};
    w_div = (rt_val == 32'd0) ? 32'd1 : rt_val;
    w_a   = rs_val[31] ? -rs_val : rs_val;
    w_b   = rt_val[31] ? -rt_val : w_div;
    w_q   = w_a / w_b;
    w_r   = w_a % w_b;
    w_uq  = rs_val / w_div;
    w_ur  = rs_val % w_div;
    w_dz  = md_op[1] && (rt_val == 32'd0);
    w_res = (md_op[1:0] == 2'd0) ? w_ms :
            (md_op[1:0] == 2'd1) ? w_mu :
            (md_op[1:0] == 2'd2) ? {rs_val[31] ? -w_r : w_r, (rs_val[31] ^ rt_val[31]) ? -w_q : w_q} :
                                   {w_ur, w_uq};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_wr    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      if (r_state == IDLE) begin
        if (start && !md_op[2]) begin
          r_pend  <= w_res;
          r_wr    <= !w_dz;
          r_cnt   <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          busy    <= 1'b1;
          r_state <= RUN;
        end else if (start && md_op == 3'd4) begin
          hi <= rs_val;
        end else if (start && md_op == 3'd5) begin
          lo <= rs_val;
        end
      end else begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          if (r_wr) {hi, lo} <= r_pend;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors; expected HI/LO queued at issue and checked on each done pulse.
module tb_mdu_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          n_vec = 0, n_bad = 0, n_done = 0;
  logic [63:0] sb[$];
  logic [63:0] m;
  mdu_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL done_unexpected: done=1 with hi=%h lo=%h and no queued result", hi, lo);
      end else begin
        chk("sb_hilo", {hi, lo}, sb.pop_front());
      end
    end
  end
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int n, input bit inj);
    int d0;
    d0 = n_done;
    sb.push_back(exp);
    issue(op, a, b);
    for (int i = 1; i <= n; i++) begin
      chk($sformatf("busy_c%0d", i), 64'(busy), 64'd1);
      chk($sformatf("hold_c%0d", i), {hi, lo}, m);
      if (inj && i == 2) begin start = 1'b1; md_op = 3'd3; rs_val = 32'd9; rt_val = 32'd3; end
      if (inj && i == 3) begin md_op = 3'd4; rs_val = 32'hDEAD; end
      if (inj && i == 4) start = 1'b0;
      @(negedge clk);
    end
    chk("busy_end", 64'(busy), 64'd0);
    chk("done_pulse", 64'(done), 64'd1);
    chk("result", {hi, lo}, exp);
    @(negedge clk);
    chk("done_once", 64'(done), 64'd0);
    chk("done_count", 64'(n_done), 64'(d0 + 1));
    m = exp;
  endtask
  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0; m = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    run(3'd0, 32'hFFFFFFFE, 32'd3,        {32'hFFFFFFFF, 32'hFFFFFFFA}, 5,  1'b0);
    run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, 5,  1'b0);
    run(3'd2, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 10, 1'b0);
    run(3'd2, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 10, 1'b0);
    run(3'd3, 32'hFFFFFFFF, 32'h10,       {32'h0000000F, 32'h0FFFFFFF}, 10, 1'b0);
    issue(3'd4, 32'h11, 32'h0);
    m = {32'h11, m[31:0]};
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_hilo", {hi, lo}, m);
    issue(3'd5, 32'h22, 32'h0);
    m = {m[63:32], 32'h22};
    chk("mtlo_busy", 64'(busy), 64'd0);
    chk("mtlo_done", 64'(done), 64'd0);
    chk("mtlo_hilo", {hi, lo}, m);
    issue(3'd6, 32'h55, 32'h66);
    chk("nop_busy", 64'(busy), 64'd0);
    chk("nop_hilo", {hi, lo}, m);
    run(3'd3, 32'd5, 32'd0, m, 10, 1'b0);
    run(3'd0, 32'd7, 32'hFFFFFFFD, {32'hFFFFFFFF, 32'hFFFFFFEB}, 5, 1'b1);
    d0 = n_done;
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    repeat (12) @(negedge clk);
    chk("abort_no_done", 64'(n_done), 64'(d0));
    reset = 1'b1; start = 1'b1; md_op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("rst_start_busy2", 64'(busy), 64'd0);
    chk("rst_start_hilo", {hi, lo}, 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
